// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller: FSM state encoding and NOP encoding.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package hazard_pkg;

  localparam int HZ_STATE_W = 2;

  typedef enum logic [HZ_STATE_W-1:0] {
    RUN           = 2'd0,
    LU_STALL      = 2'd1,
    MEM_WAIT      = 2'd2,
    REDIRECT_PEND = 2'd3
  } hz_state_t;

  // Canonical RISC-V NOP (addi x0, x0, 0) loaded by the flush/bubble paths downstream.
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear, used for hazard perf counters.
// Latency: count reflects an increment one cycle after inc is sampled.
// Backpressure: none; holds at all-ones once saturated.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] cnt_q;

  // Clear wins over increment; stop at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (clr) begin
      cnt_q <= '0;
    end else if (inc && (cnt_q != {W{1'b1}})) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  assign count = cnt_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline; HAZARD_PERF_CNT_EN enables the perf counters.
// Latency: zero-cycle; control outputs are combinational from the registered state and inputs.
// Backpressure: dmem_stall freezes all stages; imem_stall holds PC and keeps a redirect pending.
module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load_use_hazard,
  input  logic            branch_taken_EX,
  input  logic [XLEN-1:0] branch_target_EX,
  input  logic            imem_stall,
  input  logic            dmem_stall,
  output logic            pc_we,
  output logic            pc_sel_redirect,
  output logic [XLEN-1:0] pc_redirect_target,
  output logic            IFID_en,
  output logic            IDEX_en,
  output logic            EXMEM_en,
  output logic            MEMWB_en,
  output logic            IFID_flush,
  output logic            IDEX_flush,
  output logic            EXMEM_bubble,
  output logic [1:0]      hz_state,
  output logic [31:0]     stall_cycles,
  output logic [31:0]     redirect_count
);

  hz_state_t       state_q, state_d;
  // pend_q carries the redirect intent separately from state_q so that a
  // memory wait in the middle of a pending redirect does not lose it.
  logic            pend_q, pend_d;
  logic [XLEN-1:0] tgt_q, tgt_d;

  // Priority-ordered decode of stall, bubble, flush and redirect controls.
  always_comb begin
    pc_we           = 1'b1;
    pc_sel_redirect = 1'b0;
    IFID_en         = 1'b1;
    IDEX_en         = 1'b1;
    EXMEM_en        = 1'b1;
    MEMWB_en        = 1'b1;
    IFID_flush      = 1'b0;
    IDEX_flush      = 1'b0;
    EXMEM_bubble    = 1'b0;
    state_d         = RUN;
    pend_d          = pend_q;
    tgt_d           = tgt_q;

    if (rst) begin
      pc_we        = 1'b0;
      IFID_en      = 1'b0;
      IDEX_en      = 1'b0;
      EXMEM_en     = 1'b0;
      MEMWB_en     = 1'b0;
      IFID_flush   = 1'b1;
      IDEX_flush   = 1'b1;
      EXMEM_bubble = 1'b1;
      pend_d       = 1'b0;
      tgt_d        = '0;
    end else if (dmem_stall) begin
      // Whole pipe frozen; any pending redirect and its target survive.
      pc_we    = 1'b0;
      IFID_en  = 1'b0;
      IDEX_en  = 1'b0;
      EXMEM_en = 1'b0;
      MEMWB_en = 1'b0;
      state_d  = MEM_WAIT;
    end else if (load_use_hazard && (state_q != LU_STALL)) begin
      // Hold IF/ID and ID/EX, let the load drain to WB, bubble behind it.
      // A branch in EX is re-presented next cycle since ID/EX is held.
      pc_we        = 1'b0;
      IFID_en      = 1'b0;
      IDEX_en      = 1'b0;
      EXMEM_bubble = 1'b1;
      state_d      = LU_STALL;
    end else if (branch_taken_EX || pend_q) begin
      pc_sel_redirect = 1'b1;
      IFID_flush      = 1'b1;
      IDEX_flush      = 1'b1;
      if (!imem_stall) begin
        pend_d  = 1'b0;
        state_d = RUN;
      end else begin
        pc_we   = 1'b0;
        pend_d  = 1'b1;
        state_d = REDIRECT_PEND;
        // Capture only on the first stalled cycle; later EX values are flushed junk.
        if (!pend_q) begin
          tgt_d = branch_target_EX;
        end
      end
    end else if (imem_stall) begin
      pc_we      = 1'b0;
      IFID_flush = 1'b1;
    end
  end

  // State, pending flag and latched target registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      pend_q  <= 1'b0;
      tgt_q   <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      tgt_q   <= tgt_d;
    end
  end

  assign pc_redirect_target = rst ? '0 : (pend_q ? tgt_q : branch_target_EX);
  assign hz_state           = state_q;

`ifdef HAZARD_PERF_CNT_EN
  sat_counter #(.W(32)) u_stall_cnt (
    .clk   (clk),
    .clr   (rst),
    .inc   (!rst && !pc_we),
    .count (stall_cycles)
  );

  sat_counter #(.W(32)) u_redir_cnt (
    .clk   (clk),
    .clr   (rst),
    .inc   (pc_we && pc_sel_redirect),
    .count (redirect_count)
  );
`else
  assign stall_cycles   = '0;
  assign redirect_count = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed scoreboard bench for pipeline_hazard_ctrl.
// Latency: expectations are checked in the same cycle the stimulus is applied.
// Backpressure: n/a.
module tb_pipeline_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load_use_hazard = 1'b0;
  logic        branch_taken_EX = 1'b0;
  logic [31:0] branch_target_EX = '0;
  logic        imem_stall = 1'b0;
  logic        dmem_stall = 1'b0;
  logic        pc_we, pc_sel_redirect;
  logic [31:0] pc_redirect_target;
  logic        IFID_en, IDEX_en, EXMEM_en, MEMWB_en;
  logic        IFID_flush, IDEX_flush, EXMEM_bubble;
  logic [1:0]  hz_state;
  logic [31:0] stall_cycles, redirect_count;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [15:0] id;
    logic        we;
    logic        sel;
    logic [31:0] tgt;
    logic [3:0]  en;   // {IFID, IDEX, EXMEM, MEMWB}
    logic [2:0]  fl;   // {IFID_flush, IDEX_flush, EXMEM_bubble}
    logic [1:0]  st;
    logic        cc;
    logic [31:0] sc;
    logic [31:0] rc;
  } exp_t;

  exp_t exp_q[$];
  logic [15:0] vec_id = '0;

  pipeline_hazard_ctrl #(.XLEN(32)) dut (
    .clk                (clk),
    .rst                (rst),
    .load_use_hazard    (load_use_hazard),
    .branch_taken_EX    (branch_taken_EX),
    .branch_target_EX   (branch_target_EX),
    .imem_stall         (imem_stall),
    .dmem_stall         (dmem_stall),
    .pc_we              (pc_we),
    .pc_sel_redirect    (pc_sel_redirect),
    .pc_redirect_target (pc_redirect_target),
    .IFID_en            (IFID_en),
    .IDEX_en            (IDEX_en),
    .EXMEM_en           (EXMEM_en),
    .MEMWB_en           (MEMWB_en),
    .IFID_flush         (IFID_flush),
    .IDEX_flush         (IDEX_flush),
    .EXMEM_bubble       (EXMEM_bubble),
    .hz_state           (hz_state),
    .stall_cycles       (stall_cycles),
    .redirect_count     (redirect_count)
  );

  always #5 clk = ~clk;

  // Counter values only exist when the perf feature is built in.
  function automatic logic [31:0] cexp(input logic [31:0] v);
`ifdef HAZARD_PERF_CNT_EN
    return v;
`else
    return 32'h0 & v;
`endif
  endfunction

  // Apply one cycle of inputs and queue the response expected in that cycle.
  task automatic step(input logic r, input logic lu, input logic br, input logic [31:0] bt,
                      input logic ims, input logic dms,
                      input logic we, input logic sel, input logic [31:0] et,
                      input logic [3:0] en, input logic [2:0] fl, input logic [1:0] st,
                      input logic cc, input logic [31:0] sc, input logic [31:0] rc);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; load_use_hazard = lu; branch_taken_EX = br; branch_target_EX = bt;
    imem_stall = ims; dmem_stall = dms;
    vec_id = vec_id + 16'd1;
    e.id = vec_id; e.we = we; e.sel = sel; e.tgt = et; e.en = en; e.fl = fl; e.st = st;
    e.cc = cc; e.sc = cexp(sc); e.rc = cexp(rc);
    exp_q.push_back(e);
  endtask

  task automatic do_rst(input logic [1:0] st);
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 4'b0000, 3'b111, st, 1'b0, 32'h0, 32'h0);
  endtask

  // Monitor: compare the DUT against the oldest queued expectation each cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if ({pc_we, pc_sel_redirect, IFID_en, IDEX_en, EXMEM_en, MEMWB_en,
             IFID_flush, IDEX_flush, EXMEM_bubble} !== {e.we, e.sel, e.en, e.fl}) begin
          errors++;
          $display("FAIL ctrl vec %0d: got we=%b sel=%b en=%b fl=%b want we=%b sel=%b en=%b fl=%b",
                   e.id, pc_we, pc_sel_redirect, {IFID_en, IDEX_en, EXMEM_en, MEMWB_en},
                   {IFID_flush, IDEX_flush, EXMEM_bubble}, e.we, e.sel, e.en, e.fl);
        end
        checks++;
        if (pc_redirect_target !== e.tgt) begin
          errors++;
          $display("FAIL target vec %0d: got %h want %h", e.id, pc_redirect_target, e.tgt);
        end
        checks++;
        if (hz_state !== e.st) begin
          errors++;
          $display("FAIL state vec %0d: got %0d want %0d", e.id, hz_state, e.st);
        end
        if (e.cc) begin
          checks++;
          if (stall_cycles !== e.sc) begin
            errors++;
            $display("FAIL stall_cycles vec %0d: got %h want %h", e.id, stall_cycles, e.sc);
          end
          checks++;
          if (redirect_count !== e.rc) begin
            errors++;
            $display("FAIL redirect_count vec %0d: got %h want %h", e.id, redirect_count, e.rc);
          end
        end
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "timeout");
  end

  // Stimulus: directed vectors with hand-computed responses.
  initial begin
    // Reset for 3 cycles, then free-running pipe.
    do_rst(2'd0);
    do_rst(2'd0);
    step(1, 0, 0, 32'h0, 0, 0, 0, 0, 32'h0, 4'b0000, 3'b111, 2'd0, 1, 32'd0, 32'd0);
    step(0, 0, 0, 32'h0, 0, 0, 1, 0, 32'h0, 4'b1111, 3'b000, 2'd0, 1, 32'd0, 32'd0);

    // Load-use held two cycles: one stall, then masked.
    step(0, 1, 0, 32'h0, 0, 0, 0, 0, 32'h0, 4'b0011, 3'b001, 2'd0, 0, 32'd0, 32'd0);
    step(0, 1, 0, 32'h0, 0, 0, 1, 0, 32'h0, 4'b1111, 3'b000, 2'd1, 0, 32'd0, 32'd0);
    step(0, 0, 0, 32'h0, 0, 0, 1, 0, 32'h0, 4'b1111, 3'b000, 2'd0, 1, 32'd1, 32'd0);

    // Taken branch with two fetch-stall cycles; live target changes meanwhile.
    do_rst(2'd0);
    step(0, 0, 1, 32'h0000_0100, 1, 0, 0, 1, 32'h0000_0100, 4'b1111, 3'b110, 2'd0, 0, 32'd0, 32'd0);
    step(0, 0, 0, 32'hDEAD_BEEF, 1, 0, 0, 1, 32'h0000_0100, 4'b1111, 3'b110, 2'd3, 0, 32'd0, 32'd0);
    step(0, 0, 0, 32'hDEAD_BEEF, 0, 0, 1, 1, 32'h0000_0100, 4'b1111, 3'b110, 2'd3, 0, 32'd0, 32'd0);
    step(0, 0, 0, 32'hDEAD_BEEF, 0, 0, 1, 0, 32'hDEAD_BEEF, 4'b1111, 3'b000, 2'd0, 1, 32'd2, 32'd1);

    // Load-use and branch in the same cycle: stall wins, branch follows.
    do_rst(2'd0);
    step(0, 1, 1, 32'h0000_0200, 0, 0, 0, 0, 32'h0000_0200, 4'b0011, 3'b001, 2'd0, 0, 32'd0, 32'd0);
    step(0, 0, 1, 32'h0000_0200, 0, 0, 1, 1, 32'h0000_0200, 4'b1111, 3'b110, 2'd1, 0, 32'd0, 32'd0);
    step(0, 0, 0, 32'h0,         0, 0, 1, 0, 32'h0,         4'b1111, 3'b000, 2'd0, 1, 32'd1, 32'd1);

    // Memory wait of 4 cycles while a redirect is pending, then resume.
    do_rst(2'd0);
    step(0, 0, 1, 32'h0000_0300, 1, 0, 0, 1, 32'h0000_0300, 4'b1111, 3'b110, 2'd0, 0, 32'd0, 32'd0);
    step(0, 0, 0, 32'h0, 1, 1, 0, 0, 32'h0000_0300, 4'b0000, 3'b000, 2'd3, 0, 32'd0, 32'd0);
    step(0, 0, 0, 32'h0, 1, 1, 0, 0, 32'h0000_0300, 4'b0000, 3'b000, 2'd2, 0, 32'd0, 32'd0);
    step(0, 0, 0, 32'h0, 0, 1, 0, 0, 32'h0000_0300, 4'b0000, 3'b000, 2'd2, 0, 32'd0, 32'd0);
    step(0, 0, 0, 32'h0, 0, 1, 0, 0, 32'h0000_0300, 4'b0000, 3'b000, 2'd2, 0, 32'd0, 32'd0);
    step(0, 0, 0, 32'h0, 0, 0, 1, 1, 32'h0000_0300, 4'b1111, 3'b110, 2'd2, 0, 32'd0, 32'd0);
    step(0, 0, 0, 32'h0, 0, 0, 1, 0, 32'h0,         4'b1111, 3'b000, 2'd0, 1, 32'd5, 32'd1);
    // Fetch stall alone: PC held, IF/ID flushed.
    step(0, 0, 0, 32'h0, 1, 0, 0, 0, 32'h0, 4'b1111, 3'b100, 2'd0, 0, 32'd0, 32'd0);
    step(0, 0, 0, 32'h0, 0, 0, 1, 0, 32'h0, 4'b1111, 3'b000, 2'd0, 1, 32'd6, 32'd1);

    // Reset in the middle of a pending redirect discards the latched target.
    step(0, 0, 1, 32'h0000_0500, 1, 0, 0, 1, 32'h0000_0500, 4'b1111, 3'b110, 2'd0, 0, 32'd0, 32'd0);
    do_rst(2'd3);
    step(0, 0, 0, 32'h0000_0077, 0, 0, 1, 0, 32'h0000_0077, 4'b1111, 3'b000, 2'd0, 1, 32'd0, 32'd0);

    // Saturation: preload both counters to all-ones, then stall and redirect.
    do_rst(2'd0);
    step(0, 0, 0, 32'h0, 0, 0, 1, 0, 32'h0, 4'b1111, 3'b000, 2'd0, 0, 32'd0, 32'd0);
`ifdef HAZARD_PERF_CNT_EN
    force dut.u_stall_cnt.cnt_q = 32'hFFFF_FFFF;
    force dut.u_redir_cnt.cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.u_stall_cnt.cnt_q;
    release dut.u_redir_cnt.cnt_q;
`endif
    step(0, 0, 1, 32'h0000_0040, 0, 0, 1, 1, 32'h0000_0040, 4'b1111, 3'b110, 2'd0, 0, 32'd0, 32'd0);
    step(0, 0, 0, 32'h0, 1, 0, 0, 0, 32'h0, 4'b1111, 3'b100, 2'd0, 0, 32'd0, 32'd0);
    step(0, 0, 0, 32'h0, 0, 0, 1, 0, 32'h0, 4'b1111, 3'b000, 2'd0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
